descrambler_xor_8bits: RTL and testbench

DESCRAMBLER_XOR_8BITS -- requirements
Module: descrambler_xor_8bits

---
 rtl/descrambler_xor_8bits.sv | 70 +++++++
 tb/tb_descrambler_xor_8bits.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/descrambler_xor_8bits.sv
// Self-synchronous-free byte descrambler: XORs each accepted byte with an 8-bit
// Fibonacci LFSR keystream; ready/valid on both sides, one-cycle latency.
module descrambler_xor_8bits #(
  parameter logic [7:0] POLY = 8'hB8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_load,
  input  logic [7:0] seed,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] byte_count,
  output logic       busy
);

  localparam int unsigned W = 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   key;
  logic           feedback;
  logic           xfer;

  assign feedback = ^(key & POLY);
  assign in_ready = (state_q == RUN) && !seed_load && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  // Next-state: any seed_load enters (or stays in) RUN; only rst returns to IDLE
  always_comb begin
    state_d = state_q;
    if (seed_load) state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
    end
  end

  // Datapath: seed load flushes the pending byte; key advances once per accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key        <= W'(1);
      out_data   <= '0;
      out_valid  <= 1'b0;
      byte_count <= '0;
    end else if (seed_load) begin
      key        <= (seed == '0) ? W'(1) : seed;
      out_valid  <= 1'b0;
      byte_count <= '0;
    end else if (xfer) begin
      out_data   <= in_data ^ key;
      key        <= {key[W-2:0], feedback};
      out_valid  <= 1'b1;
      byte_count <= byte_count + W'(1);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_descrambler_xor_8bits.sv
// Bench for descrambler_xor_8bits: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_descrambler_xor_8bits;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [7:0] byte_count;
  logic       busy;

  int n_chk = 0;
  int n_pass = 0;

  descrambler_xor_8bits #(.POLY(8'hB8)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .byte_count(byte_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Keystream step: shift left, new LSB = parity of tapped bits
  function automatic logic [7:0] next_key(input logic [7:0] k);
    int p;
    p = $countones(k & 8'hB8) % 2;
    return 8'((int'(k) * 2 + p) % 256);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model
  logic       m_run;
  logic [7:0] m_key, m_data, m_count;
  logic       m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_key <= 8'h01; m_data <= 8'h00; m_valid <= 1'b0; m_count <= 8'h00;
    end else if (seed_load) begin
      m_run <= 1'b1; m_key <= (seed == 8'h00) ? 8'h01 : seed;
      m_valid <= 1'b0; m_count <= 8'h00;
    end else if (m_run && in_valid && (!m_valid || out_ready)) begin
      m_data <= in_data ^ m_key; m_key <= next_key(m_key);
      m_valid <= 1'b1; m_count <= m_count + 8'd1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    check("out_valid", int'(out_valid), int'(m_valid));
    check("out_data", int'(out_data), int'(m_data));
    check("byte_count", int'(byte_count), int'(m_count));
    check("busy", int'(busy), int'(m_run));
    check("in_ready", int'(in_ready), int'(m_run && !seed_load && (!m_valid || out_ready)));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] s);
    seed_load = 1'b1; seed = s; in_valid = 1'b0;
    step();
    seed_load = 1'b0;
  endtask

  logic [7:0] lit5 [5];
  logic [7:0] plain [16];
  logic [7:0] ks;

  initial begin
    lit5[0] = 8'h01; lit5[1] = 8'h02; lit5[2] = 8'h04; lit5[3] = 8'h08; lit5[4] = 8'h11;

    // Reset state and idle after release
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    step(); step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    step(); step();
    check("idle_no_accept", int'(out_valid), 0);
    check("idle_busy", int'(busy), 0);

    // Seed 01, five zero bytes back to back
    load(8'h01);
    check("busy_after_load", int'(busy), 1);
    in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("ks_seed01", int'(out_data), int'(lit5[i]));
      check("ks_valid", int'(out_valid), 1);
    end
    check("count5", int'(byte_count), 5);

    // Seed 00 gives the same keystream as seed 01
    load(8'h00);
    in_valid = 1'b1; in_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ks_seed00", int'(out_data), int'(lit5[i]));
    end

    // Backpressure
    load(8'h01);
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    step();
    check("bp_first", int'(out_data), 8'hA4);
    in_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", int'(out_data), 8'hA4);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release", int'(out_data), 8'h02);

    // Round trip against a bench-side scrambler seeded 5A
    ks = 8'h5A;
    for (int i = 0; i < 16; i++) plain[i] = 8'($urandom_range(0, 255));
    load(8'h5A);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = plain[i] ^ ks; ks = next_key(ks);
      step();
      check("roundtrip", int'(out_data), int'(plain[i]));
    end

    // Count wrap after 256 transfers
    load(8'h01);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'($urandom_range(0, 255));
      step();
    end
    check("wrap_count", int'(byte_count), 0);
    check("wrap_valid", int'(out_valid), 1);

    // Reseed with a pending output
    out_ready = 1'b0; in_data = 8'h77;
    step();
    load(8'h33);
    check("reseed_valid", int'(out_valid), 0);
    check("reseed_count", int'(byte_count), 0);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h12;
    step(); step();
    #1 rst = 1'b1;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_data", int'(out_data), 0);
    check("arst_count", int'(byte_count), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_in_ready", int'(in_ready), 0);
    step();
    rst = 1'b0;
    step(); step(); step();
    check("post_rst_ignored", int'(out_valid), 0);

    // Randomized traffic, occasional reseed and reset
    load(8'($urandom_range(0, 255)));
    for (int i = 0; i < 3000; i++) begin
      seed_load = ($urandom_range(0, 49) == 0);
      seed      = 8'($urandom_range(0, 255));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; seed_load = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
